// File: rtl/regbank_4x64_sb_if.sv
// Writeback, read and issue signals of the 4x64 register bank with scoreboard.
// The master drives writes, read addresses and issue requests; the slave is the bank.
interface regbank_4x64_sb_if #(
  parameter int WIDTH = 64
);
  logic [3:0]       wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [1:0]       rd_addr_a;
  logic [1:0]       rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             issue_valid;
  logic [1:0]       issue_dst;
  logic [1:0]       issue_src_a;
  logic [1:0]       issue_src_b;
  logic             stall;
  logic [3:0]       busy;
  logic             onehot_err;

  modport master (
    output wr_en, wr_data, rd_addr_a, rd_addr_b,
    output issue_valid, issue_dst, issue_src_a, issue_src_b,
    input  rd_data_a, rd_data_b, stall, busy, onehot_err
  );

  modport slave (
    input  wr_en, wr_data, rd_addr_a, rd_addr_b,
    input  issue_valid, issue_dst, issue_src_a, issue_src_b,
    output rd_data_a, rd_data_b, stall, busy, onehot_err
  );
endinterface

// File: rtl/regbank_4x64_sb.sv
// 4-entry register bank, 2 read / 1 write, with write-to-read bypass and a
// busy-bit scoreboard that stalls issue while a source or destination is pending.
module regbank_4x64_sb #(
  parameter int WIDTH = 64
) (
  input logic              clk,
  input logic              reset,
  regbank_4x64_sb_if.slave bus
);

  logic [WIDTH-1:0] regs_q [4];
  logic [WIDTH-1:0] regs_d [4];
  logic [3:0]       busy_q;
  logic [3:0]       busy_d;
  logic             onehot_err_q;
  logic             onehot_err_d;

  logic             multi_hot;
  logic [3:0]       legal_we;
  logic [3:0]       eff_busy;
  logic [3:0]       set_mask;
  logic             stall;

  // x & (x-1) is nonzero exactly when two or more bits are set; such writes are dropped.
  always_comb begin
    multi_hot    = |(bus.wr_en & (bus.wr_en - 4'd1));
    legal_we     = multi_hot ? 4'b0000 : bus.wr_en;
    eff_busy     = busy_q & ~legal_we;
    stall        = bus.issue_valid & (eff_busy[bus.issue_src_a] |
                                      eff_busy[bus.issue_src_b] |
                                      eff_busy[bus.issue_dst]);
    set_mask     = (bus.issue_valid && !stall) ? (4'b0001 << bus.issue_dst) : 4'b0000;
    // Set is OR'd after the clear so a new producer on the same register wins.
    busy_d       = eff_busy | set_mask;
    onehot_err_d = multi_hot;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_reg_next
    assign regs_d[gi] = legal_we[gi] ? bus.wr_data : regs_q[gi];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
      busy_q       <= 4'b0000;
      onehot_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q       <= busy_d;
      onehot_err_q <= onehot_err_d;
    end
  end

  assign bus.rd_data_a  = legal_we[bus.rd_addr_a] ? bus.wr_data : regs_q[bus.rd_addr_a];
  assign bus.rd_data_b  = legal_we[bus.rd_addr_b] ? bus.wr_data : regs_q[bus.rd_addr_b];
  assign bus.stall      = stall;
  assign bus.busy       = busy_q;
  assign bus.onehot_err = onehot_err_q;

endmodule

// File: tb/tb_regbank_4x64_sb.sv
// Scoreboard bench for regbank_4x64_sb: directed scenarios then random traffic,
// each cycle's expected outputs queued by the driver and checked by a monitor.
module tb_regbank_4x64_sb;

  logic clk;
  logic reset;

  regbank_4x64_sb_if #(.WIDTH(64)) bus ();

  regbank_4x64_sb #(.WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] rd_a;
    logic [63:0] rd_b;
    logic        stall;
    logic [3:0]  busy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: what the bank holds after the most recent rising edge.
  logic [63:0] m_regs [4];
  bit          m_busy [4];
  bit          m_err;

  function automatic bit m_eff_busy(input int r, input int n_hot, input int widx);
    return m_busy[r] && !(n_hot == 1 && widx == r);
  endfunction

  // Apply one cycle of inputs: queue the expected outputs, then advance the model.
  task automatic cycle(input bit rst_n, input logic [3:0] we, input logic [63:0] wd,
                       input int ra, input int rb, input bit iv,
                       input int dst, input int sa, input int sb);
    exp_t e;
    int   n_hot;
    int   widx;
    bit   st;
    bus.wr_en       = we;
    bus.wr_data     = wd;
    bus.rd_addr_a   = 2'(ra);
    bus.rd_addr_b   = 2'(rb);
    bus.issue_valid = iv;
    bus.issue_dst   = 2'(dst);
    bus.issue_src_a = 2'(sa);
    bus.issue_src_b = 2'(sb);
    reset           = rst_n;

    n_hot = $countones(we);
    widx  = -1;
    for (int i = 0; i < 4; i++) if (we[i]) widx = i;

    e.rd_a  = (n_hot == 1 && widx == ra) ? wd : m_regs[ra];
    e.rd_b  = (n_hot == 1 && widx == rb) ? wd : m_regs[rb];
    st      = iv && (m_eff_busy(sa, n_hot, widx) || m_eff_busy(sb, n_hot, widx) ||
                     m_eff_busy(dst, n_hot, widx));
    e.stall = st;
    e.busy  = {m_busy[3], m_busy[2], m_busy[1], m_busy[0]};
    e.err   = m_err;
    exp_q.push_back(e);

    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_regs[i] = 64'd0;
        m_busy[i] = 1'b0;
      end
      m_err = 1'b0;
    end else begin
      if (n_hot == 1) begin
        m_regs[widx] = wd;
        m_busy[widx] = 1'b0;
      end
      if (iv && !st) m_busy[dst] = 1'b1;
      m_err = (n_hot > 1);
    end

    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle presents outputs; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.rd_data_a !== e.rd_a) begin
          errors++;
          $display("FAIL rd_data_a got %h expected %h", bus.rd_data_a, e.rd_a);
        end
        checks++;
        if (bus.rd_data_b !== e.rd_b) begin
          errors++;
          $display("FAIL rd_data_b got %h expected %h", bus.rd_data_b, e.rd_b);
        end
        checks++;
        if (bus.stall !== e.stall) begin
          errors++;
          $display("FAIL stall got %b expected %b", bus.stall, e.stall);
        end
        checks++;
        if (bus.busy !== e.busy) begin
          errors++;
          $display("FAIL busy got %b expected %b", bus.busy, e.busy);
        end
        checks++;
        if (bus.onehot_err !== e.err) begin
          errors++;
          $display("FAIL onehot_err got %b expected %b", bus.onehot_err, e.err);
        end
        $display("txn t=%0t rd_a=%h rd_b=%h stall=%b busy=%b err=%b",
                 $time, bus.rd_data_a, bus.rd_data_b, bus.stall, bus.busy, bus.onehot_err);
      end
    end
  end

  initial begin
    logic [3:0]  we;
    logic [63:0] wd;
    int          sel;

    reset           = 1'b0;
    bus.wr_en       = 4'b0000;
    bus.wr_data     = 64'd0;
    bus.rd_addr_a   = 2'd2;
    bus.rd_addr_b   = 2'd3;
    bus.issue_valid = 1'b0;
    bus.issue_dst   = 2'd0;
    bus.issue_src_a = 2'd0;
    bus.issue_src_b = 2'd0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      m_regs[i] = 64'd0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;

    // Reset sequence: second reset cycle, then released.
    cycle(0, 4'b0000, 64'd0, 2, 3, 0, 0, 0, 0);
    cycle(1, 4'b0000, 64'd0, 2, 3, 0, 0, 0, 0);

    // Write then read, with same-cycle bypass.
    cycle(1, 4'b0100, 64'hDEADBEEF_CAFEF00D, 2, 0, 0, 0, 0, 0);
    cycle(1, 4'b0000, 64'd0, 2, 3, 0, 0, 0, 0);
    cycle(1, 4'b0000, 64'd0, 1, 0, 0, 0, 0, 0);

    // Multi-hot write is dropped and flagged for one cycle.
    cycle(1, 4'b0010, 64'h5, 0, 1, 0, 0, 0, 0);
    cycle(1, 4'b0011, 64'hFFFF, 0, 1, 0, 0, 0, 0);
    cycle(1, 4'b0000, 64'd0, 0, 1, 0, 0, 0, 0);
    cycle(1, 4'b0000, 64'd0, 0, 1, 0, 0, 0, 0);

    // Scoreboard hazard, then writeback releasing it.
    cycle(1, 4'b0000, 64'd0, 0, 0, 1, 1, 0, 0);
    cycle(1, 4'b0000, 64'd0, 0, 0, 1, 3, 1, 0);
    cycle(1, 4'b0000, 64'd0, 0, 0, 0, 0, 0, 0);
    cycle(1, 4'b0010, 64'h1234, 1, 3, 1, 3, 1, 1);
    cycle(1, 4'b0000, 64'd0, 1, 3, 0, 0, 0, 0);

    // Set-wins collision, then mid-operation reset.
    cycle(1, 4'b0000, 64'd0, 0, 0, 1, 2, 0, 0);
    cycle(1, 4'b0100, 64'hABCD, 2, 0, 1, 2, 0, 0);
    cycle(1, 4'b0000, 64'd0, 2, 0, 0, 0, 0, 0);
    cycle(0, 4'b0000, 64'd0, 0, 1, 0, 0, 0, 0);
    cycle(1, 4'b0000, 64'd0, 0, 1, 0, 0, 0, 0);
    cycle(1, 4'b0000, 64'd0, 2, 3, 0, 0, 0, 0);

    // Random traffic: mostly one-hot writes, some idle and some multi-hot.
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      we = 4'b0001 << $urandom_range(0, 3);
      else if (sel < 8) we = 4'b0000;
      else begin
        we = 4'($urandom);
        if ($countones(we) < 2) we = 4'b1010;
      end
      wd = {$urandom, $urandom};
      cycle(($urandom_range(0, 49) != 0), we, wd,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 2) != 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank_4x64_sb.md
Name: regbank_4x64_sb

Overview:
- 4-entry × 64-bit register bank with a 2-read/1-write port arrangement and a busy-bit scoreboard.
- Consumes the one-hot write enables produced by the 2-to-4 write-select decoder.
- Sits directly downstream of that decoder in the writeback stage.
- Provides same-cycle write-to-read bypass.
- Raises an issue-stage stall when a source or destination register has a write still outstanding.

Parameters:
- WIDTH, 64, data width of each register.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising clk.
- wr_en  input  4  one-hot write enable from the decoder; bit i writes register i.
- wr_data  input  WIDTH  writeback data.
- rd_addr_a  input  2  read port A address.
- rd_addr_b  input  2  read port B address.
- rd_data_a  output  WIDTH  read port A data (combinational).
- rd_data_b  output  WIDTH  read port B data (combinational).
- issue_valid  input  1  an instruction is requesting issue this cycle.
- issue_dst  input  2  destination register of the issuing instruction.
- issue_src_a  input  2  first source register of the issuing instruction.
- issue_src_b  input  2  second source register of the issuing instruction.
- stall  output  1  issue blocked this cycle (combinational).
- busy  output  4  registered scoreboard bits; bit i set means a write to register i is outstanding.
- onehot_err  output  1  registered one-cycle pulse flagging an illegal multi-hot wr_en.

Behaviour:
- Reset (reset==0 at a rising clk):
  - All four registers clear to 0.
  - busy clears to 4'b0000.
  - onehot_err clears to 0.
  - Reset overrides any simultaneous write or issue.
  - Mid-operation reset discards outstanding busy bits; no pending writes survive.
- Write legality:
  - wr_en is legal when it is zero-hot or exactly one-hot.
  - Legal one-hot: register i takes wr_data at the rising edge; visible on registered reads the next cycle.
  - wr_en==0: no write occurs.
  - Multi-hot (2, 3 or 4 bits set): no register is written and busy is not cleared.
  - For multi-hot, onehot_err is 1 for exactly the following cycle; otherwise onehot_err is 0 each cycle.
- Reads:
  - Combinational from the register array.
  - Bypass: if a legal one-hot wr_en targets the read address in the same cycle, rd_data returns wr_data.
  - Both ports bypass independently; both may read the same address.
- Scoreboard clear:
  - A legal write to register i clears busy[i] at the edge.
- Scoreboard set:
  - When issue_valid==1 and stall==0, busy[issue_dst] sets at the edge.
  - If the same register is set and cleared in one cycle, set wins (the new producer stays outstanding).
  - Set and clear on different registers apply independently.
- Stall equation:
  - stall = issue_valid & (eff_busy[issue_src_a] | eff_busy[issue_src_b] | eff_busy[issue_dst]).
  - eff_busy = busy with the bit of any same-cycle legal write already cleared, so a writeback bypasses the hazard in the same cycle.
  - stall is 0 whenever issue_valid==0.
- Latency:
  - Write: 1 cycle.
  - Read: 0 cycles.
  - busy update: 1 cycle.
  - onehot_err: 1 cycle after the offending wr_en.
- Operands duplicated across src_a, src_b and dst are legal; no special case is needed.

Test Plan:
1. Reset sequence:
   - Stimulus: reset=0 for 2 cycles, then 1; rd_addr_a=2, rd_addr_b=3.
   - Response: rd_data_a=rd_data_b=0; busy=0000; onehot_err=0; stall=0.
2. Write then read:
   - Stimulus: wr_en=0100, wr_data=64'hDEADBEEF_CAFEF00D; rd_addr_a=2 in the same cycle, and again the next cycle.
   - Response: rd_data_a=DEADBEEF_CAFEF00D in the same cycle (bypass) and in the next cycle; registers 0, 1 and 3 unchanged.
3. Multi-hot write:
   - Stimulus: register 1 holds 64'h5; drive wr_en=0011, wr_data=64'hFFFF for one cycle.
   - Response: register 0 = 0 and register 1 = 5 (both unchanged); onehot_err=1 for exactly one cycle, then 0.
4. Scoreboard hazard:
   - Stimulus: issue_valid=1, dst=1, srcs=0,0; next cycle issue_valid=1, src_a=1, dst=3.
   - Response: busy=0010 after the first cycle; stall=1 in the second cycle; busy[3] not set.
5. Writeback releases stall:
   - Stimulus: with busy=0010, issue src_a=1, dst=3 while wr_en=0010 in the same cycle.
   - Response: stall=0; the next cycle busy=1000.
6. Set-wins collision and mid-operation reset:
   - Collision stimulus: busy=0100, wr_en=0100, issue dst=2, srcs=0,0.
   - Collision response: stall=0; busy stays 0100.
   - Reset stimulus: then assert reset=0.
   - Reset response: busy=0000; all registers read 0.
